// File: rtl/traffic_light_controller_actuated_pkg.sv
// Shared definitions for the actuated traffic light controller:
// light-head encodings and the controller state type.
package tlc_pkg;

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_GREEN  = 2'b10;
   localparam logic [1:0] LIGHT_OFF    = 2'b11;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_A = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_B = 3'd5,
      FLASH     = 3'd6
   } tlc_state_t;

endpackage

// File: rtl/traffic_light_controller_actuated_if.sv
// Sensor/request inputs and light-head outputs of the controller.
interface tlc_if;

   logic       ew_sensor;
   logic       ped_req;
   logic       flash_mode;
   logic [1:0] NS_light;
   logic [1:0] EW_light;
   logic       ped_walk;

   modport master (
      output ew_sensor, ped_req, flash_mode,
      input  NS_light, EW_light, ped_walk
   );

   modport slave (
      input  ew_sensor, ped_req, flash_mode,
      output NS_light, EW_light, ped_walk
   );

endinterface

// File: rtl/traffic_light_controller_actuated_phase_timer.sv
// Loadable down-counter that saturates at zero; expired while the count is zero.
module tlc_phase_timer #(
   parameter int unsigned          CNT_W   = 8,
   parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;

   // Count register: reset value, load on phase entry, otherwise count down to 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= RST_VAL;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_controller_actuated.sv
// Sensor-actuated two-road traffic light controller. NS rests in green; EW is
// served on demand with sensor-driven green extension; night flash mode is
// entered and left only through an all-red clearance.
module traffic_light_controller_actuated
   import tlc_pkg::*;
#(
   parameter int unsigned GREEN_NS   = 8,
   parameter int unsigned GREEN_EW   = 6,
   parameter int unsigned YELLOW     = 3,
   parameter int unsigned ALL_RED    = 2,
   parameter int unsigned MAX_EXT    = 4,
   parameter int unsigned FLASH_HALF = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic  clk,
   input  logic  rst,
   tlc_if.slave  bus
);

   localparam logic [CNT_W-1:0] T_NSG = CNT_W'(GREEN_NS - 1);
   localparam logic [CNT_W-1:0] T_EWG = CNT_W'(GREEN_EW - 1);
   localparam logic [CNT_W-1:0] T_Y   = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] T_FH  = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] X_MAX = CNT_W'(MAX_EXT);

   tlc_state_t       state_q, state_d;
   logic [CNT_W-1:0] ext_q, ext_d;
   logic             pend_q, pend_d;
   logic             walk_q, walk_d;
   logic             fph_q, fph_d;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             expired;
   logic [1:0]       ns_dec, ew_dec;

   // The same timer paces the phases and, while in FLASH, the flash half-period.
   tlc_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (T_NSG)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (expired)
   );

   // State and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= NS_GREEN;
         ext_q   <= '0;
         pend_q  <= 1'b0;
         walk_q  <= 1'b0;
         fph_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ext_q   <= ext_d;
         pend_q  <= pend_d;
         walk_q  <= walk_d;
         fph_q   <= fph_d;
      end
   end

   // Next-state, timer reloads and pedestrian/extension/flash bookkeeping.
   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_val  = '0;
      ext_d      = ext_q;
      pend_d     = pend_q;
      walk_d     = walk_q;
      fph_d      = fph_q;

      // A request while the walk is already showing has been served and is dropped.
      if (bus.ped_req && !(state_q == EW_GREEN && walk_q)) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         NS_GREEN: begin
            if (expired && (bus.ew_sensor || pend_q || bus.flash_mode)) begin
               state_d    = NS_YELLOW;
               timer_load = 1'b1;
               timer_val  = T_Y;
            end
         end
         NS_YELLOW: begin
            if (expired) begin
               state_d    = ALL_RED_A;
               timer_load = 1'b1;
               timer_val  = T_AR;
            end
         end
         ALL_RED_A: begin
            if (expired) begin
               timer_load = 1'b1;
               if (bus.flash_mode) begin
                  state_d   = FLASH;
                  timer_val = T_FH;
                  fph_d     = 1'b0;
               end else begin
                  // Entry edge: the latched request becomes the walk, and the
                  // clear wins over any request arriving on this same edge.
                  state_d   = EW_GREEN;
                  timer_val = T_EWG;
                  walk_d    = pend_q;
                  pend_d    = 1'b0;
                  ext_d     = '0;
               end
            end
         end
         EW_GREEN: begin
            if (expired) begin
               if (bus.ew_sensor && (ext_q < X_MAX)) begin
                  ext_d = ext_q + 1'b1;
               end else begin
                  state_d    = EW_YELLOW;
                  timer_load = 1'b1;
                  timer_val  = T_Y;
                  walk_d     = 1'b0;
               end
            end
         end
         EW_YELLOW: begin
            if (expired) begin
               state_d    = ALL_RED_B;
               timer_load = 1'b1;
               timer_val  = T_AR;
            end
         end
         ALL_RED_B: begin
            if (expired) begin
               timer_load = 1'b1;
               if (bus.flash_mode) begin
                  state_d   = FLASH;
                  timer_val = T_FH;
                  fph_d     = 1'b0;
               end else begin
                  state_d   = NS_GREEN;
                  timer_val = T_NSG;
               end
            end
         end
         FLASH: begin
            if (!bus.flash_mode) begin
               state_d    = ALL_RED_B;
               timer_load = 1'b1;
               timer_val  = T_AR;
               fph_d      = 1'b0;
            end else if (expired) begin
               fph_d      = ~fph_q;
               timer_load = 1'b1;
               timer_val  = T_FH;
            end
         end
         default: begin
            state_d    = NS_GREEN;
            timer_load = 1'b1;
            timer_val  = T_NSG;
         end
      endcase
   end

   // Moore decode of the light heads from registered state.
   always_comb begin
      ns_dec = LIGHT_RED;
      ew_dec = LIGHT_RED;
      unique case (state_q)
         NS_GREEN:  ns_dec = LIGHT_GREEN;
         NS_YELLOW: ns_dec = LIGHT_YELLOW;
         EW_GREEN:  ew_dec = LIGHT_GREEN;
         EW_YELLOW: ew_dec = LIGHT_YELLOW;
         FLASH: begin
            ns_dec = fph_q ? LIGHT_OFF : LIGHT_YELLOW;
            ew_dec = fph_q ? LIGHT_OFF : LIGHT_RED;
         end
         default: begin
            ns_dec = LIGHT_RED;
            ew_dec = LIGHT_RED;
         end
      endcase
   end

   assign bus.NS_light = ns_dec;
   assign bus.EW_light = ew_dec;
   assign bus.ped_walk = walk_q;

endmodule

// File: tb/tb_traffic_light_controller_actuated.sv
// Self-checking bench for traffic_light_controller_actuated: directed scenarios
// followed by random stimulus, all compared every cycle against a phase/elapsed-time
// reference model, plus safety invariants on the observed light heads.
module tb_traffic_light_controller_actuated;

   localparam int GREEN_NS   = 8;
   localparam int GREEN_EW   = 6;
   localparam int YELLOW     = 3;
   localparam int ALL_RED    = 2;
   localparam int MAX_EXT    = 4;
   localparam int FLASH_HALF = 4;

   localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4, P_ARB = 5, P_FL = 6;

   logic clk = 1'b0;
   logic rst;
   tlc_if bus ();

   traffic_light_controller_actuated #(
      .GREEN_NS   (GREEN_NS),
      .GREEN_EW   (GREEN_EW),
      .YELLOW     (YELLOW),
      .ALL_RED    (ALL_RED),
      .MAX_EXT    (MAX_EXT),
      .FLASH_HALF (FLASH_HALF),
      .CNT_W      (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: current phase, cycles elapsed in it, and side bookkeeping.
   int m_ph, m_el, m_ext, m_fc;
   bit m_pend, m_walk, m_fph;
   int dur [7] = '{GREEN_NS, YELLOW, ALL_RED, GREEN_EW, YELLOW, ALL_RED, FLASH_HALF};

   logic [1:0] prev_ns, prev_ew;

   task automatic model_edge(input bit r, input bit s, input bit p, input bit f);
      int nph;
      bit done, pend_old;
      if (!r) begin
         m_ph = P_NSG; m_el = 0; m_ext = 0; m_fc = 0;
         m_pend = 0; m_walk = 0; m_fph = 0;
         return;
      end
      nph      = m_ph;
      done     = (m_el >= dur[m_ph] - 1);
      pend_old = m_pend;
      if (p && !(m_ph == P_EWG && m_walk)) m_pend = 1;
      case (m_ph)
         P_NSG: if (done && (s || pend_old || f)) nph = P_NSY;
         P_NSY: if (done) nph = P_ARA;
         P_ARA: if (done) nph = f ? P_FL : P_EWG;
         P_EWG: if (done) begin
                   if (s && m_ext < MAX_EXT) m_ext++;
                   else nph = P_EWY;
                end
         P_EWY: if (done) nph = P_ARB;
         P_ARB: if (done) nph = f ? P_FL : P_NSG;
         P_FL:  if (!f) begin
                   nph = P_ARB; m_fph = 0;
                end else begin
                   m_fc++;
                   if (m_fc == FLASH_HALF) begin m_fph = !m_fph; m_fc = 0; end
                end
         default: nph = P_NSG;
      endcase
      if (nph != m_ph) begin
         m_el = 0;
         if (nph == P_EWG) begin m_walk = pend_old; m_pend = 0; m_ext = 0; end
         if (nph == P_EWY) m_walk = 0;
         if (nph == P_FL) begin m_fc = 0; m_fph = 0; end
         m_ph = nph;
      end else begin
         m_el++;
      end
   endtask

   task automatic check_outputs(input bit r);
      logic [1:0] ens, eew;
      logic       ewk;
      case (m_ph)
         P_NSG:   begin ens = 2'b10; eew = 2'b00; end
         P_NSY:   begin ens = 2'b01; eew = 2'b00; end
         P_EWG:   begin ens = 2'b00; eew = 2'b10; end
         P_EWY:   begin ens = 2'b00; eew = 2'b01; end
         P_FL:    begin ens = m_fph ? 2'b11 : 2'b01; eew = m_fph ? 2'b11 : 2'b00; end
         default: begin ens = 2'b00; eew = 2'b00; end
      endcase
      ewk = m_walk;

      checks++;
      assert (bus.NS_light === ens) else begin
         errors++;
         $error("FAIL ns_light cyc %0d: observed %b expected %b", cyc, bus.NS_light, ens);
      end
      checks++;
      assert (bus.EW_light === eew) else begin
         errors++;
         $error("FAIL ew_light cyc %0d: observed %b expected %b", cyc, bus.EW_light, eew);
      end
      checks++;
      assert (bus.ped_walk === ewk) else begin
         errors++;
         $error("FAIL ped_walk cyc %0d: observed %b expected %b", cyc, bus.ped_walk, ewk);
      end
      checks++;
      assert (m_ph == P_FL || bus.NS_light === 2'b00 || bus.EW_light === 2'b00) else begin
         errors++;
         $error("FAIL both_non_red cyc %0d: observed NS %b EW %b expected one red", cyc, bus.NS_light, bus.EW_light);
      end
      checks++;
      assert (!bus.ped_walk || bus.NS_light === 2'b00) else begin
         errors++;
         $error("FAIL walk_ns_red cyc %0d: observed NS %b expected 00", cyc, bus.NS_light);
      end
      if (r) begin
         checks++;
         assert (!((prev_ns == 2'b10 && bus.NS_light !== 2'b10) || (prev_ew == 2'b10 && bus.EW_light !== 2'b10))
                 || bus.NS_light === 2'b01 || bus.EW_light === 2'b01) else begin
            errors++;
            $error("FAIL green_to_yellow cyc %0d: observed NS %b EW %b expected a yellow", cyc, bus.NS_light, bus.EW_light);
         end
         checks++;
         assert (!(prev_ew == 2'b01 && bus.EW_light !== 2'b01) || bus.EW_light === 2'b00) else begin
            errors++;
            $error("FAIL ew_yellow_to_red cyc %0d: observed EW %b expected 00", cyc, bus.EW_light);
         end
      end
      prev_ns = bus.NS_light;
      prev_ew = bus.EW_light;
   endtask

   task automatic step(input bit r, input bit s, input bit p, input bit f);
      rst            = r;
      bus.ew_sensor  = s;
      bus.ped_req    = p;
      bus.flash_mode = f;
      @(posedge clk);
      model_edge(r, s, p, f);
      #1;
      cyc++;
      check_outputs(r);
   endtask

   // Runs n identical steps, counting observed EW-green and walk cycles.
   task automatic run_count(input bit s, input bit f, input int n, output int ewg, output int walk);
      ewg  = 0;
      walk = 0;
      for (int i = 0; i < n; i++) begin
         step(1, s, 0, f);
         if (bus.EW_light === 2'b10) ewg++;
         if (bus.ped_walk === 1'b1) walk++;
      end
   endtask

   initial begin
      int  ewg, walk;
      bit  found;
      bit  rr, rs, rp, rf;

      prev_ns = 2'b10;
      prev_ew = 2'b00;
      rst = 1'b0; bus.ew_sensor = 1'b0; bus.ped_req = 1'b0; bus.flash_mode = 1'b0;

      // 1: reset and idle
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      run_count(0, 0, 50, ewg, walk);
      checks++;
      assert (ewg == 0) else begin
         errors++;
         $error("FAIL idle_no_ew: observed %0d expected 0", ewg);
      end

      // 2: single EW sensor pulse at cycle 20 after reset
      step(0, 0, 0, 0);
      for (int i = 0; i < 19; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      run_count(0, 0, 40, ewg, walk);
      checks++;
      assert (ewg == GREEN_EW) else begin
         errors++;
         $error("FAIL ew_base_green: observed %0d expected %0d", ewg, GREEN_EW);
      end

      // 3: sensor held high -> fully extended EW green
      run_count(1, 0, 30, ewg, walk);
      checks++;
      assert (ewg == GREEN_EW + MAX_EXT) else begin
         errors++;
         $error("FAIL ew_extended: observed %0d expected %0d", ewg, GREEN_EW + MAX_EXT);
      end
      run_count(0, 0, 30, ewg, walk);

      // 4: pedestrian pulse in NS green
      step(1, 0, 1, 0);
      run_count(0, 0, 40, ewg, walk);
      checks++;
      assert (walk == GREEN_EW) else begin
         errors++;
         $error("FAIL walk_len: observed %0d expected %0d", walk, GREEN_EW);
      end
      checks++;
      assert (ewg == GREEN_EW) else begin
         errors++;
         $error("FAIL ped_ew_green: observed %0d expected %0d", ewg, GREEN_EW);
      end

      // 5: flash entry and exit
      run_count(0, 1, 40, ewg, walk);
      run_count(0, 0, 20, ewg, walk);

      // 6: reset on the 3rd EW green cycle with walk active
      step(1, 0, 1, 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1, 0, 0, 0);
         if (bus.EW_light === 2'b10 && bus.ped_walk === 1'b1) found = 1;
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL reach_walk: observed %0d expected 1", found);
      end
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      run_count(0, 0, 50, ewg, walk);
      checks++;
      assert (ewg == 0) else begin
         errors++;
         $error("FAIL no_pending_after_reset: observed %0d expected 0", ewg);
      end

      // Random stimulus against the model
      rf = 0;
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 299) != 0);
         rs = ($urandom_range(0, 3) == 0);
         rp = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 149) == 0) rf = !rf;
         step(rr, rs, rp, rf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
